clkdiv_prog: RTL

Parametrised successor to the free-running divider. It keeps a WIDTH-bit free-running count for legacy users. It adds NCH independent programmable channels, each producing a one-cycle tick (clock-enable) and a 50%-duty square wave. Divisors are reprogrammed at run time through a valid/ready port and take effect glitch-free at the channel's next wrap. It sits beside the top-level clock, feeding scan/refresh/debounce logic that today taps fixed bits of the old counter.

---
 rtl/clkdiv_pkg.sv | 18 +
 rtl/clkdiv_chan.sv | 55 +++++
 rtl/clkdiv_prog.sv | 57 +++++
 3 files changed

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Channel state is sized for the widest supported divisor; narrower DIV_W leaves upper bits at zero.
package clkdiv_pkg;

  localparam int DIV_MAX_W      = 32;
  localparam int CLKDIV_DEF_DIV = 2;

  typedef struct packed {
    logic [DIV_MAX_W-1:0] div;
    logic [DIV_MAX_W-1:0] pend_div;
    logic                 pending;
  } chan_cfg_t;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One programmable divider channel: counter, tick/square outputs and
// deferred divisor update that only lands on a wrap (or at once when off).
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DEF_DIV = CLKDIV_DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  output logic             pending,
  output logic             tick,
  output logic             sq
);

  chan_cfg_t            cfg;
  logic [DIV_W-1:0]     c;
  logic [DIV_MAX_W-1:0] c_nxt;
  logic                 off;
  logic                 wrap;

  // c < div always, so the widened c+1 never overflows
  assign c_nxt   = DIV_MAX_W'(c) + DIV_MAX_W'(1);
  assign off     = (cfg.div == '0);
  assign wrap    = en && !off && (c_nxt == cfg.div);
  assign pending = cfg.pending;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c            <= '0;
      tick         <= 1'b0;
      sq           <= 1'b0;
      cfg.div      <= DIV_MAX_W'(DEF_DIV);
      cfg.pend_div <= '0;
      cfg.pending  <= 1'b0;
    end else begin
      tick <= wrap;
      if (wrap) sq <= ~sq;
      if (off || wrap) c <= '0;
      else if (en)     c <= c + DIV_W'(1);
      // wr is only ever asserted while nothing is pending, so the two never collide
      if ((off || wrap) && cfg.pending) begin
        cfg.div     <= cfg.pend_div;
        cfg.pending <= 1'b0;
      end else if (wr) begin
        cfg.pend_div <= DIV_MAX_W'(wr_div);
        cfg.pending  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_prog.sv
// Programmable clock divider: legacy free-running count plus NCH channels
// whose divisors are rewritten through a valid/ready port.
module clkdiv_prog
  import clkdiv_pkg::*;
#(
  parameter  int WIDTH   = 32,
  parameter  int NCH     = 4,
  parameter  int DIV_W   = 16,
  parameter  int DEF_DIV = CLKDIV_DEF_DIV,
  localparam int CH_W    = ch_idx_w(NCH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   sq
);

  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    cnt <= '0;
    else if (en) cnt <= cnt + WIDTH'(1);
  end

  // Out-of-range channel numbers stay ready and are silently dropped
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NCH; i++)
      if (cfg_ch == CH_W'(i)) cfg_ready = ~pend[i];
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign wr[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    clkdiv_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .wr      (wr[i]),
      .wr_div  (cfg_div),
      .pending (pend[i]),
      .tick    (tick[i]),
      .sq      (sq[i])
    );
  end

endmodule
